// File: rtl/replica_sequencer.sv
// -----------------------------------------------------------------------------
// replica_sequencer
//   Top-level sweep sequencer for the NREP metropolis replicas. Each sweep runs
//   exp init -> exp evaluation -> wait for delta -> metropolis update ->
//   distance shift, followed every EXCH_INTERVAL sweeps by an even/odd
//   neighbour exchange phase. Sweeps are counted up to a host-programmed limit.
//
//   Optional feature macro: SEQ_PERF_EN (adds perf_cycles / perf_exch).
//
// Ports
//   clk            in   clock
//   reset          in   asynchronous, active-low reset
//   start          in   pulse in IDLE: latch n_iter and begin (ignored when busy)
//   stop           in   abort request, honoured at the next sweep boundary
//   n_iter         in   number of sweeps to run
//   delta_valid    in   delta_distance of all replicas valid
//   exch_accept    in   bit i: pair (i,i+1) passes the exchange test
//   exp_init       out  exp seed strobe
//   exp_run        out  exp iteration enable
//   metropolis_run out  metropolis accept/update strobe
//   distance_shift out  replica data shift strobe
//   command        out  exchange command per replica, [2i+1:2i] = replica i
//   busy           out  high while a run is in progress (INIT..EXCH)
//   done           out  1-cycle pulse at end of run or abort
//   sweep_cnt      out  sweeps completed this run
//   perf_cycles    out  (SEQ_PERF_EN) busy cycles this run, saturating
//   perf_exch      out  (SEQ_PERF_EN) accepted pairs this run, saturating
//
// Handshake: start is a single-cycle request accepted only in IDLE; there is
// no ready signal, the caller watches busy/done. delta_valid is a level that
// is only looked at while waiting for delta.
// -----------------------------------------------------------------------------
module replica_sequencer #(
   parameter int NREP          = 32,
   parameter int EXP_CYCLES    = 17,
   parameter int SHIFT_CYCLES  = 1,
   parameter int EXCH_INTERVAL = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic [31:0]         n_iter,
   input  logic                delta_valid,
   input  logic [NREP-2:0]     exch_accept,
   output logic                exp_init,
   output logic                exp_run,
   output logic                metropolis_run,
   output logic                distance_shift,
   output logic [2*NREP-1:0]   command,
   output logic                busy,
   output logic                done,
   output logic [31:0]         sweep_cnt
`ifdef SEQ_PERF_EN
   ,
   output logic [31:0]         perf_cycles,
   output logic [31:0]         perf_exch
`endif
);

   // exchange_command_t encoding
   localparam logic [1:0] CMD_NOP  = 2'd0;
   localparam logic [1:0] CMD_FOLW = 2'd1;
   localparam logic [1:0] CMD_PREV = 2'd2;

   localparam int CMAX = (EXP_CYCLES > SHIFT_CYCLES) ? EXP_CYCLES : SHIFT_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int XW   = $clog2(EXCH_INTERVAL + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_EXP, S_WAITD, S_METRO, S_SHIFT, S_EXCH, S_FIN
   } state_t;

   state_t              state, state_n;
   logic [CW-1:0]       cnt;        // cycles spent in the current EXP/SHIFT phase
   logic [XW-1:0]       exch_cnt;   // sweeps since the last exchange phase
   logic [31:0]         n_iter_q;
   logic                parity;
   logic                stop_req;
   logic [2*NREP-1:0]   cmd_calc;

   logic                start_acc;
   logic                in_run;
   logic                stop_pend;
   logic                shift_last;
   logic                exch_due;
   logic [31:0]         sweep_inc;

   assign start_acc  = (state == S_IDLE) && start;
   assign in_run     = (state != S_IDLE) && (state != S_FIN);
   // A stop arriving in the same cycle as the boundary decision still counts.
   assign stop_pend  = stop_req | stop;
   assign shift_last = (state == S_SHIFT) && (cnt == CW'(SHIFT_CYCLES - 1));
   assign exch_due   = (exch_cnt == XW'(EXCH_INTERVAL - 1));
   assign sweep_inc  = sweep_cnt + 32'd1;

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (start) state_n = (n_iter != 32'd0) ? S_INIT : S_FIN;
         S_INIT:  state_n = S_EXP;
         S_EXP:   if (cnt == CW'(EXP_CYCLES - 1)) state_n = S_WAITD;
         S_WAITD: if (delta_valid) state_n = S_METRO;
         S_METRO: state_n = S_SHIFT;
         S_SHIFT: begin
            if (cnt == CW'(SHIFT_CYCLES - 1)) begin
               if (exch_due)                                state_n = S_EXCH;
               else if ((sweep_inc == n_iter_q) || stop_pend) state_n = S_FIN;
               else                                         state_n = S_INIT;
            end
         end
         S_EXCH:  state_n = ((sweep_cnt == n_iter_q) || stop_pend) ? S_FIN : S_INIT;
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Exchange pairs (i,i+1) whose lower index matches the current parity.
   always_comb begin
      cmd_calc = '0;
      for (int i = 0; i < NREP - 1; i++) begin
         if ((((i % 2) != 0) == parity) && exch_accept[i]) begin
            cmd_calc[2*i +: 2]     = CMD_FOLW;
            cmd_calc[2*i + 2 +: 2] = CMD_PREV;
         end
      end
   end

   // State, counters and registered (Moore) outputs decoded from next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         exch_cnt       <= '0;
         n_iter_q       <= '0;
         parity         <= 1'b0;
         stop_req       <= 1'b0;
         sweep_cnt      <= '0;
         exp_init       <= 1'b0;
         exp_run        <= 1'b0;
         metropolis_run <= 1'b0;
         distance_shift <= 1'b0;
         command        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= (state_n != state) ? '0 : cnt + CW'(1);

         if (start_acc) begin
            n_iter_q  <= n_iter;
            sweep_cnt <= '0;
            exch_cnt  <= '0;
            stop_req  <= 1'b0;
         end else begin
            if (in_run && stop) stop_req <= 1'b1;
            if (shift_last) begin
               sweep_cnt <= sweep_inc;
               exch_cnt  <= exch_due ? '0 : exch_cnt + XW'(1);
            end
         end

         if (state == S_EXCH) parity <= ~parity;

         exp_init       <= (state_n == S_INIT);
         exp_run        <= (state_n == S_EXP);
         metropolis_run <= (state_n == S_METRO);
         distance_shift <= (state_n == S_SHIFT);
         command        <= (state_n == S_EXCH) ? cmd_calc : {NREP{CMD_NOP}};
         busy           <= (state_n != S_IDLE) && (state_n != S_FIN);
         done           <= (state_n == S_FIN);
      end
   end

`ifdef SEQ_PERF_EN
   logic [31:0] pair_cnt;
   logic [32:0] exch_sum;

   // Accepted pairs currently presented: one FOLW field per pair.
   always_comb begin
      pair_cnt = '0;
      for (int i = 0; i < NREP; i++) begin
         if (command[2*i +: 2] == CMD_FOLW) pair_cnt = pair_cnt + 32'd1;
      end
      exch_sum = {1'b0, perf_exch} + {1'b0, pair_cnt};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_cycles <= '0;
         perf_exch   <= '0;
      end else if (start_acc) begin
         perf_cycles <= '0;
         perf_exch   <= '0;
      end else begin
         if (busy && (perf_cycles != 32'hFFFF_FFFF)) perf_cycles <= perf_cycles + 32'd1;
         perf_exch <= exch_sum[32] ? 32'hFFFF_FFFF : exch_sum[31:0];
      end
   end
`endif

endmodule
